mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sits directly downstream of `request_unit` and serialises its instruction-fetch and data-access requests onto one single-port memory bus. It returns the `i_ready`/`d_ready` completion pulses and the `imemloadi`/`dmmloadi` data that `request_unit` consumes. Data accesses take priority over fetches. A watchdog aborts bus transactions that are never acknowledged.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum bus-wait cycles before abort. Legal range 2–255.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, synchronous, active-low.
- `imemRen` in 1: fetch request, level-sensitive.
- `imemaddr` in 32: fetch address.
- `dmmRen` in 1: data-read request, one-cycle pulse.
- `dmmWen` in 1: data-write request, one-cycle pulse.
- `dmmaddr` in 32: data address.
- `dmmstore` in 32: store data.
- `dmm_be` in 4: store byte enables.
- `i_ready` out 1: fetch-complete pulse.
- `d_ready` out 1: data-complete pulse.
- `imemload` out 32: last fetched word.
- `dmmload` out 32: last loaded word.
- `bus_req` out 1: bus request.
- `bus_wen` out 1: bus write.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_be` out 4: bus byte enables.
- `bus_rdata` in 32: bus read data.
- `bus_ack` in 1: bus completion, one cycle.
- `bus_err` out 1: timeout pulse.
- `d_overrun` out 1: sticky; a data request was lost.

## Operation
- **Reset values:** all outputs 0; state `IDLE`; pending flag clear; timeout counter 0.
- **Data pending register:**
  - A `dmmRen` or `dmmWen` pulse in any state sets `d_pend` and captures `dmmaddr`, `dmmstore`, `dmm_be` and a write flag.
  - Write flag = `dmmWen`. If both `dmmRen` and `dmmWen` are high, the access is a write.
  - A pulse while `d_pend` is already set is dropped and sets `d_overrun`. `d_overrun` is cleared only by reset.
- **State `IDLE`:**
  - If `d_pend`, go to `DACC`. Load `bus_addr`, `bus_wen`, `bus_wdata` and `bus_be` from the pending register, and clear `d_pend`.
  - Else if `imemRen`, go to `IFETCH` with `bus_addr=imemaddr`, `bus_wen=0`, `bus_be=4'hF`.
  - `bus_req` is 1 in the cycle after leaving `IDLE`.
- **States `IFETCH` / `DACC`:**
  - `bus_req`, `bus_addr`, `bus_wen`, `bus_wdata` and `bus_be` are held stable until `bus_ack`.
  - On `bus_ack`, return to `IDLE`.
  - On `bus_ack` in `IFETCH`: register `bus_rdata` into `imemload` and pulse `i_ready` in the next cycle.
  - On `bus_ack` in `DACC`: pulse `d_ready` in the next cycle. Also register `bus_rdata` into `dmmload` when the access is a read; stores leave `dmmload` unchanged.
- **Timeout:**
  - The 8-bit counter clears on entering `IFETCH`/`DACC` and increments each cycle `bus_req=1` with no `bus_ack`.
  - When it reaches `TIMEOUT` without ack: drop `bus_req`, return to `IDLE`, pulse `bus_err` for 1 cycle.
  - On a timeout there is no ready pulse and `imemload`/`dmmload` are unchanged. An aborted data access is not retried.
- **Ack timing:** `bus_ack` sampled in `IDLE` is ignored. `bus_ack` arriving in the same cycle the counter hits `TIMEOUT` counts as success.

## Timing
- All outputs are registered; the only combinational path is to the next-state logic.
- **Fetch:** request seen in `IDLE` at cycle 0 → `bus_req=1` at cycle 1 → `bus_ack` at cycle k ≥ 1 → `i_ready=1` and `imemload` valid at cycle k+1, state `IDLE`. Minimum request-to-ready is 2 cycles.
- **Dead cycle:** `bus_req` is 0 for at least one cycle between transactions, the `IDLE` cycle.
- **Ready pulses:** `i_ready`, `d_ready` and `bus_err` are exactly one cycle wide and mutually exclusive.
- **Priority:** a data pulse arriving during a fetch is served immediately after that fetch. The next fetch waits for the data access to complete.
- **Reset mid-transaction:** on the next edge, drop `bus_req`, return to `IDLE`, clear pending, no ready pulse.

## Structure
- Shared package (with `cuOPType`):
  - `arb_state_t` enum {`IDLE`, `IFETCH`, `DACC`}.
  - Constant `BE_WORD = 4'hF`.
- Sub-module `arb_timeout_ctr`: clear, enable, `TIMEOUT` compare, `expired` output.
- Everything else lives in one FSM module.

## Test plan
- **Reset:** hold `nRST=0` for 2 cycles with `bus_ack` toggling → all outputs 0, `bus_req` stays 0.
- **Fetch:** `imemRen=1`, `imemaddr=0x100`, memory acks after 3 cycles with `0x00500093` → `bus_addr=0x100` stable, `i_ready` 1 cycle, `imemload=0x00500093`.
- **Load priority:** `dmmRen` pulse during a fetch, `dmmaddr=0x2000` → fetch completes, next transaction is a read of `0x2000`; ack data `0xDEADBEEF` → `d_ready` pulse, `dmmload=0xDEADBEEF`.
- **Store and overrun:** `dmmWen` pulse with `dmmaddr=0x2004`, `dmmstore=0x12345678`, `be=4'b0011`, then a second pulse while pending → `bus_wen=1` with `bus_wdata`/`bus_be` matching the first pulse, `dmmload` unchanged, `d_overrun=1`.
- **Timeout:** `TIMEOUT=4`, memory never acks → `bus_req` high for 4 cycles, then `bus_err` 1-cycle pulse, no `i_ready`, then a new fetch starts.
- **Reset mid-access:** assert `nRST=0` during `DACC` before ack → `bus_req=0` and state `IDLE` next cycle, no `d_ready`, pending cleared.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Types and constants shared by the memory arbiter and its neighbours in
//   the request path.
//   - arb_state_t : arbiter FSM states
//   - d_req_t     : captured data-access request (pending register contents)
//   - cuOPType    : control-unit operation class, shared with request_unit
//   - BE_WORD     : full-word byte-enable mask used for instruction fetches
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ALU    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5
  } cuOPType;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wen;
  } d_req_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// arb_timeout_ctr
//   8-bit bus-wait counter. Cleared while the arbiter is idle, counts every
//   cycle the bus is requested but not acknowledged.
//   Ports:
//     CLK, nRST : clock, synchronous active-low reset
//     clear     : hold the count at zero
//     enable    : a wait cycle (bus_req high, no bus_ack)
//     expired   : this wait cycle is the one that brings the count to TIMEOUT
module arb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Compare against TIMEOUT-1 so the abort lands on the same edge the count
  // would reach TIMEOUT; bus_req is then high for exactly TIMEOUT cycles.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises instruction fetches and data accesses onto one single-port
//   memory bus. Data accesses win over fetches; a watchdog aborts bus
//   transactions that are never acknowledged.
//
//   state  | meaning
//   IDLE   | bus released; picks pending data access, else a fetch
//   IFETCH | instruction fetch on the bus, waiting for bus_ack
//   DACC   | data read/write on the bus, waiting for bus_ack
//
//   Ports:
//     CLK, nRST                       : clock, synchronous active-low reset
//     imemRen, imemaddr               : level-sensitive fetch request
//     dmmRen, dmmWen, dmmaddr,
//     dmmstore, dmm_be                : one-cycle data request pulses
//     i_ready, imemload               : fetch-complete pulse, fetched word
//     d_ready, dmmload                : data-complete pulse, loaded word
//     bus_req, bus_wen, bus_addr,
//     bus_wdata, bus_be               : memory bus request side
//     bus_rdata, bus_ack              : memory bus response side
//     bus_err                         : watchdog abort pulse
//     d_overrun                       : sticky, a data request was dropped
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [3:0]  dmm_be,
  output logic        i_ready,
  output logic        d_ready,
  output logic [31:0] imemload,
  output logic [31:0] dmmload,
  output logic        bus_req,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        d_overrun
);

  arb_state_t state;
  d_req_t     d_req;
  logic       d_pend;
  logic       to_expired;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .enable  (bus_req && !bus_ack),
    .expired (to_expired)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      d_req     <= '0;
      d_pend    <= 1'b0;
      d_overrun <= 1'b0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
      imemload  <= '0;
      dmmload   <= '0;
      bus_req   <= 1'b0;
      bus_wen   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      bus_err <= 1'b0;

      // A new request while one is still pending is dropped, even in the
      // cycle IDLE is consuming the pending one.
      if (dmmRen || dmmWen) begin
        if (d_pend) begin
          d_overrun <= 1'b1;
        end else begin
          d_pend      <= 1'b1;
          d_req.addr  <= dmmaddr;
          d_req.wdata <= dmmstore;
          d_req.be    <= dmm_be;
          d_req.wen   <= dmmWen;
        end
      end

      case (state)
        IDLE: begin
          if (d_pend) begin
            state     <= DACC;
            d_pend    <= 1'b0;
            bus_req   <= 1'b1;
            bus_addr  <= d_req.addr;
            bus_wen   <= d_req.wen;
            bus_wdata <= d_req.wdata;
            bus_be    <= d_req.be;
          end else if (imemRen) begin
            state     <= IFETCH;
            bus_req   <= 1'b1;
            bus_addr  <= imemaddr;
            bus_wen   <= 1'b0;
            bus_wdata <= '0;
            bus_be    <= BE_WORD;
          end
        end

        IFETCH: begin
          if (bus_ack) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            imemload <= bus_rdata;
            i_ready  <= 1'b1;
          end else if (to_expired) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end

        DACC: begin
          if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            d_ready <= 1'b1;
            if (!bus_wen) dmmload <= bus_rdata;
          end else if (to_expired) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by a randomized run. The bench plays the
//   memory: a word-addressed associative array with byte-enable merging
//   supplies read data and absorbs writes, and each request's expected bus
//   fields, ready pulse and returned word come from that memory.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic [3:0]  dmm_be;
  logic        i_ready;
  logic        d_ready;
  logic [31:0] imemload;
  logic [31:0] dmmload;
  logic        bus_req;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        d_overrun;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemRen   (imemRen),
    .imemaddr  (imemaddr),
    .dmmRen    (dmmRen),
    .dmmWen    (dmmWen),
    .dmmaddr   (dmmaddr),
    .dmmstore  (dmmstore),
    .dmm_be    (dmm_be),
    .i_ready   (i_ready),
    .d_ready   (d_ready),
    .imemload  (imemload),
    .dmmload   (dmmload),
    .bus_req   (bus_req),
    .bus_wen   (bus_wen),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .d_overrun (d_overrun)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_iload;
  logic [31:0] exp_dload;
  logic        exp_ovr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, 32'({i_ready, d_ready, bus_err, d_overrun}), 32'd0);
    chk({tag, "_bus_ctl"}, 32'({bus_req, bus_wen, bus_be}), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_imemload"}, imemload, 32'd0);
    chk({tag, "_dmmload"}, dmmload, 32'd0);
  endtask

  // Called in the first cycle bus_req should be high. lat = cycle (1-based)
  // in which the memory acks; lat > TO means the memory never answers.
  // Returns one cycle after the transaction ends.
  task automatic serve(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                       input logic [3:0] be, input int lat, input logic [31:0] rd,
                       output logic acked);
    int n;
    n = (lat > TO) ? TO : lat;
    acked = (lat <= TO);
    for (int i = 1; i <= n; i++) begin
      chk("bus_req_held", 32'(bus_req), 32'd1);
      chk("bus_addr", bus_addr, a);
      chk("bus_wen", 32'(bus_wen), 32'(wen));
      chk("bus_be", 32'(bus_be), 32'(be));
      if (wen) chk("bus_wdata", bus_wdata, wd);
      chk("no_pulse_in_txn", 32'({i_ready, d_ready, bus_err}), 32'd0);
      if (i == lat) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      step();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    chk("bus_req_released", 32'(bus_req), 32'd0);
    if (!acked) chk("timeout_pulses", 32'({i_ready, d_ready, bus_err}), 32'b001);
  endtask

  // Fetch issued from IDLE; imemRen drops once the fetch is on the bus.
  task automatic do_fetch(input logic [31:0] a, input int lat);
    logic        acked;
    logic [31:0] rd;
    rd       = mem_rd(a);
    imemRen  = 1'b1;
    imemaddr = a;
    step();
    imemRen  = 1'b0;
    imemaddr = $urandom;
    serve(a, 1'b0, 32'd0, 4'hF, lat, rd, acked);
    if (acked) begin
      exp_iload = rd;
      chk("fetch_ready", 32'({i_ready, d_ready, bus_err}), 32'b100);
    end
    chk("imemload", imemload, exp_iload);
    chk("d_overrun", 32'(d_overrun), 32'(exp_ovr));
  endtask

  // Data pulse issued from IDLE with nothing pending; a write wins when
  // both strobes are high.
  task automatic do_data(input logic ren, input logic wen, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input int lat);
    logic        acked;
    logic [31:0] rd;
    rd       = wen ? $urandom : mem_rd(a);
    dmmRen   = ren;
    dmmWen   = wen;
    dmmaddr  = a;
    dmmstore = wd;
    dmm_be   = be;
    step();
    dmmRen   = 1'b0;
    dmmWen   = 1'b0;
    dmmaddr  = $urandom;
    dmmstore = $urandom;
    dmm_be   = 4'($urandom);
    chk("data_dead_cycle", 32'(bus_req), 32'd0);
    step();
    serve(a, wen, wd, be, lat, rd, acked);
    if (acked) begin
      if (wen) mem[a] = merge(mem_rd(a), wd, be);
      else     exp_dload = rd;
      chk("data_ready", 32'({i_ready, d_ready, bus_err}), 32'b010);
    end
    chk("dmmload", dmmload, exp_dload);
    chk("d_overrun", 32'(d_overrun), 32'(exp_ovr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acked;
    logic [31:0] a;
    int          kind;
    int          lat;

    nRST = 1'b0; imemRen = 1'b0; imemaddr = '0;
    dmmRen = 1'b0; dmmWen = 1'b0; dmmaddr = '0; dmmstore = '0; dmm_be = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    exp_iload = '0; exp_dload = '0; exp_ovr = 1'b0;

    // Reset with bus_ack toggling
    for (int c = 0; c < 2; c++) begin
      step();
      bus_ack = ~bus_ack;
      chk_all_zero("reset");
    end
    nRST = 1'b1;
    bus_ack = 1'b0;
    step();
    chk("reset_idle_bus_req", 32'(bus_req), 32'd0);

    // Basic fetch, ack in third bus cycle
    mem[32'h100] = 32'h00500093;
    do_fetch(32'h100, 3);
    chk("fetch_word", imemload, 32'h00500093);

    // Load arriving during a fetch; imemRen stays high throughout
    mem[32'h104]  = 32'h00A00113;
    mem[32'h2000] = 32'hDEADBEEF;
    imemRen = 1'b1; imemaddr = 32'h104;
    step();
    chk("prio_fetch_addr", bus_addr, 32'h104);
    dmmRen = 1'b1; dmmaddr = 32'h2000; dmm_be = 4'hF;
    step();
    dmmRen = 1'b0;
    chk("prio_fetch_held", bus_addr, 32'h104);
    bus_ack = 1'b1; bus_rdata = mem_rd(32'h104);
    step();
    bus_ack = 1'b0;
    exp_iload = 32'h00A00113;
    chk("prio_fetch_ready", 32'({i_ready, d_ready, bus_req}), 32'b100);
    chk("prio_imemload", imemload, exp_iload);
    step();
    serve(32'h2000, 1'b0, 32'd0, 4'hF, 1, 32'hDEADBEEF, acked);
    exp_dload = 32'hDEADBEEF;
    chk("prio_load_ready", 32'({i_ready, d_ready, bus_err}), 32'b010);
    chk("prio_dmmload", dmmload, 32'hDEADBEEF);
    step();
    imemRen = 1'b0;
    serve(32'h104, 1'b0, 32'd0, 4'hF, 2, mem_rd(32'h104), acked);
    chk("prio_next_fetch_ready", 32'(i_ready), 32'd1);

    // Store, then a second pulse while the first is still pending
    dmmWen = 1'b1; dmmaddr = 32'h2004; dmmstore = 32'h12345678; dmm_be = 4'b0011;
    step();
    dmmaddr = 32'h3000; dmmstore = 32'hCAFEF00D; dmm_be = 4'hF;
    chk("store_dead_cycle", 32'(bus_req), 32'd0);
    step();
    dmmWen = 1'b0;
    exp_ovr = 1'b1;
    chk("overrun_set", 32'(d_overrun), 32'd1);
    serve(32'h2004, 1'b1, 32'h12345678, 4'b0011, 2, 32'h0BADF00D, acked);
    mem[32'h2004] = merge(mem_rd(32'h2004), 32'h12345678, 4'b0011);
    chk("store_ready", 32'({i_ready, d_ready, bus_err}), 32'b010);
    chk("store_dmmload_kept", dmmload, 32'hDEADBEEF);
    step();
    chk("overrun_dropped_no_txn", 32'(bus_req), 32'd0);
    chk("overrun_sticky", 32'(d_overrun), 32'd1);

    // Timeout on a fetch, then the still-requested fetch restarts
    imemRen = 1'b1; imemaddr = 32'h200;
    step();
    serve(32'h200, 1'b0, 32'd0, 4'hF, TO + 5, 32'd0, acked);
    chk("timeout_imemload_kept", imemload, exp_iload);
    step();
    imemRen = 1'b0;
    serve(32'h200, 1'b0, 32'd0, 4'hF, 1, mem_rd(32'h200), acked);
    exp_iload = mem_rd(32'h200);
    chk("after_timeout_ready", 32'({i_ready, d_ready, bus_err}), 32'b100);
    chk("after_timeout_imemload", imemload, exp_iload);

    // Ack in the very cycle the counter reaches TIMEOUT is a success
    do_fetch(32'h300, TO);
    do_data(1'b1, 1'b0, 32'h2004, 32'd0, 4'hF, TO);
    chk("store_merged_readback", dmmload, merge(mem_rd(32'h2004), 32'h12345678, 4'b0000));

    // Data timeout: no retry, dmmload unchanged
    do_data(1'b1, 1'b0, 32'h2008, 32'd0, 4'hF, TO + 3);
    step();
    chk("dtimeout_no_retry", 32'(bus_req), 32'd0);

    // Reset in the middle of a data access, with a new pulse in that cycle
    dmmRen = 1'b1; dmmaddr = 32'h2000; dmm_be = 4'hF;
    step();
    dmmRen = 1'b0;
    step();
    chk("mid_reset_in_dacc", 32'(bus_req), 32'd1);
    nRST = 1'b0;
    dmmRen = 1'b1; dmmaddr = 32'h2010;
    step();
    nRST = 1'b1;
    dmmRen = 1'b0;
    exp_ovr = 1'b0; exp_iload = '0; exp_dload = '0;
    chk_all_zero("mid_reset");
    step();
    step();
    chk("mid_reset_pending_cleared", 32'(bus_req), 32'd0);
    chk("mid_reset_no_ready", 32'({i_ready, d_ready, bus_err}), 32'd0);

    // Randomized run
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      a    = 32'h4000 + 32'(4 * $urandom_range(0, 7));
      lat  = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(1, 5);
      case (kind)
        0:       do_fetch(a, lat);
        1:       do_data(1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)), lat);
        default: do_data(1'($urandom_range(0, 1)), 1'b1, a, $urandom,
                         4'($urandom_range(1, 15)), lat);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
